complex_result_accumulator: RTL



---
 rtl/complex_result_accumulator_if.sv | 45 ++++
 rtl/complex_result_accumulator.sv | 113 +++++++++++
 2 files changed

// File: rtl/complex_result_accumulator_if.sv
// Handshake bundles for the complex result accumulator: the product stream
// coming in from the multiplier and the block-sum stream going out.

// Valid/ready rule for both bundles: a transfer happens at a rising edge where
// valid and ready are both high. Once valid is raised, the master holds its
// payload stable until that transfer. Ready may not depend on valid through
// combinational logic.
interface cra_res_if #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 4
);
  logic                    res_val;
  logic                    res_ready;
  logic [2*DATA_WIDTH-1:0] result_re;
  logic [2*DATA_WIDTH-1:0] result_im;
  logic [CNT_WIDTH-1:0]    cfg_len;

  modport master (
    output res_val, result_re, result_im, cfg_len,
    input  res_ready
  );
  modport slave (
    input  res_val, result_re, result_im, cfg_len,
    output res_ready
  );
endinterface

interface cra_acc_if #(
  parameter int ACC_WIDTH = 24
);
  logic                 acc_val;
  logic                 acc_ready;
  logic [ACC_WIDTH-1:0] acc_re;
  logic [ACC_WIDTH-1:0] acc_im;
  logic                 acc_ovf;

  modport master (
    output acc_val, acc_re, acc_im, acc_ovf,
    input  acc_ready
  );
  modport slave (
    input  acc_val, acc_re, acc_im, acc_ovf,
    output acc_ready
  );
endinterface

// File: rtl/complex_result_accumulator.sv
// Accumulates blocks of complex products into wide sums (complex MAC) and
// presents each finished block sum on a held valid/ready output.

module complex_result_accumulator #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 24,
  parameter int CNT_WIDTH  = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       sw_rst,
  cra_res_if.slave   res,
  cra_acc_if.master  acc,
  output logic       o_state
);

  typedef enum logic {
    S_ACC = 1'b0,
    S_OUT = 1'b1
  } state_t;

  state_t                r_state;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic [CNT_WIDTH-1:0]  r_len;
  logic [ACC_WIDTH-1:0]  r_re;
  logic [ACC_WIDTH-1:0]  r_im;
  logic                  r_ovf;

  logic                  w_fire;
  logic                  w_first;
  logic                  w_last;
  logic [CNT_WIDTH-1:0]  w_cfg_eff;
  logic [CNT_WIDTH-1:0]  w_eff_len;
  logic [ACC_WIDTH-1:0]  w_re_ext;
  logic [ACC_WIDTH-1:0]  w_im_ext;
  logic [ACC_WIDTH-1:0]  w_sum_re;
  logic [ACC_WIDTH-1:0]  w_sum_im;
  logic                  w_ovf_re;
  logic                  w_ovf_im;

  assign res.res_ready = (r_state == S_ACC);
  assign acc.acc_val   = (r_state == S_OUT);
  assign acc.acc_re    = r_re;
  assign acc.acc_im    = r_im;
  assign acc.acc_ovf   = r_ovf;
  assign o_state       = r_state;

  assign w_fire  = res.res_val && (r_state == S_ACC);
  assign w_first = (r_cnt == '0);

  // A zero length would never reach a last beat, so it runs as a one-beat block.
  assign w_cfg_eff = (res.cfg_len == '0) ? CNT_WIDTH'(1) : res.cfg_len;
  assign w_eff_len = w_first ? w_cfg_eff : r_len;
  assign w_last    = (r_cnt == (w_eff_len - CNT_WIDTH'(1)));

  assign w_re_ext = ACC_WIDTH'($signed(res.result_re));
  assign w_im_ext = ACC_WIDTH'($signed(res.result_im));
  assign w_sum_re = r_re + w_re_ext;
  assign w_sum_im = r_im + w_im_ext;

  // Signed overflow: addends agree in sign but the wrapped sum does not.
  assign w_ovf_re = (r_re[ACC_WIDTH-1] == w_re_ext[ACC_WIDTH-1]) &&
                    (w_sum_re[ACC_WIDTH-1] != r_re[ACC_WIDTH-1]);
  assign w_ovf_im = (r_im[ACC_WIDTH-1] == w_im_ext[ACC_WIDTH-1]) &&
                    (w_sum_im[ACC_WIDTH-1] != r_im[ACC_WIDTH-1]);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_ACC;
      r_cnt   <= '0;
      r_len   <= '0;
      r_re    <= '0;
      r_im    <= '0;
      r_ovf   <= 1'b0;
    end else if (sw_rst) begin
      r_state <= S_ACC;
      r_cnt   <= '0;
      r_len   <= '0;
      r_re    <= '0;
      r_im    <= '0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_ACC: begin
          if (w_fire) begin
            if (w_first) begin
              r_len <= w_cfg_eff;
              r_re  <= w_re_ext;
              r_im  <= w_im_ext;
              r_ovf <= 1'b0;
            end else begin
              r_re <= w_sum_re;
              r_im <= w_sum_im;
              if (w_ovf_re || w_ovf_im) r_ovf <= 1'b1;
            end
            if (w_last) begin
              r_cnt   <= '0;
              r_state <= S_OUT;
            end else begin
              r_cnt <= r_cnt + CNT_WIDTH'(1);
            end
          end
        end
        S_OUT: begin
          // Sum stays on the outputs after the handoff until the next first beat.
          if (acc.acc_ready) r_state <= S_ACC;
        end
        default: r_state <= S_ACC;
      endcase
    end
  end

endmodule
